// File: rtl/score_bcd_converter.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) for the score display path.
// One registered result per start; leading-zero blanking and saturation on overflow.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CONV  | one double-dabble step per clock, BIN_W steps total
// FIN   | publish result, pulse done, return to IDLE
module score_bcd_converter #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CMP_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    function automatic logic [CMP_W-1:0] pow10(input int n);
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < n; i++) p = p * CMP_W'(10);
        return p;
    endfunction

    // 10^DIGITS always fits in 4*DIGITS bits, so CMP_W is wide enough for the limit.
    localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);

    logic [1:0]        state;
    logic [BIN_W-1:0]  sr;
    logic [BCD_W-1:0]  acc;
    logic [BCD_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  step;
    logic              ovf_pend;
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_run;
    logic [CMP_W-1:0]  bin_ext;

    assign bin_ext = CMP_W'(bin);
    assign busy    = (state != IDLE);

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Units digit is never blanked so that zero still shows a single "0".
    always_comb begin
        blank_nxt = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (acc[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_run;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            sr       <= '0;
            acc      <= '0;
            step     <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            blank    <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= bin;
                        acc      <= '0;
                        step     <= '0;
                        ovf_pend <= (bin_ext >= LIMIT);
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc <= {acc_adj[BCD_W-2:0], sr[BIN_W-1]};
                    sr  <= sr << 1;
                    if (step == CNT_W'(BIN_W - 1)) state <= FIN;
                    else                           step  <= step + CNT_W'(1);
                end
                FIN: begin
                    if (ovf_pend) begin
                        bcd      <= {DIGITS{4'h9}};
                        blank    <= '0;
                        overflow <= 1'b1;
                    end else begin
                        bcd      <= acc;
                        blank    <= blank_nxt;
                        overflow <= 1'b0;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
